ordered_cash_lookup: RTL

Request/response lookup controller that sits directly downstream of the sorted string container in the fast binary-search order cash. It accepts an address and runs a binary search over the container's address-ordered entries, one probe per clock, through the container's index/D_OUT read path. It returns either a hit with the stored data and index, or a miss with the insertion index. The insertion index is what the write path uses to place a new entry.

---
 rtl/ordered_cash_lookup.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/ordered_cash_lookup.sv
// Binary-search lookup controller over the address-ordered entries of the sorted
// container. One probe per clock. Returns a hit with data and index, or a miss with the insertion index.
module ordered_cash_lookup #(
  parameter  int address_size = 8,
  parameter  int data_size    = 8,
  parameter  int cash_length  = 16,
  localparam int W            = $clog2(cash_length)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [address_size-1:0]           req_address,
  input  logic [W:0]                        fill_count,
  output logic [W-1:0]                      mem_index,
  input  logic [address_size+data_size-1:0] mem_data,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic                              rsp_hit,
  output logic [data_size-1:0]              rsp_data,
  output logic [W:0]                        rsp_index,
  output logic [W:0]                        rsp_probes
);

  typedef enum logic [1:0] {IDLE, SEARCH, RESPOND} state_t;

  localparam logic [W:0] CASH_LEN = (W+1)'(cash_length);

  state_t state_q, state_d;

  logic [address_size-1:0] key_q, key_d;
  logic [W:0]              l_q, l_d;
  logic signed [W+1:0]     r_q, r_d;
  logic [W:0]              probes_q, probes_d;
  logic                    hit_q, hit_d;
  logic [data_size-1:0]    data_q, data_d;
  logic [W:0]              index_q, index_d;
  logic [W:0]              rprobes_q, rprobes_d;

  logic [W:0]              fill_clamped;
  logic [W+1:0]            r_init;
  logic                    search_done;
  logic [W+1:0]            mid_sum;
  logic [W:0]              mid;
  logic [address_size-1:0] entry_addr;
  logic [data_size-1:0]    entry_data;

  assign fill_clamped = (fill_count > CASH_LEN) ? CASH_LEN : fill_count;
  assign r_init       = {1'b0, fill_clamped} - (W+2)'(1);

  // The window is empty once l passes r; r may sit at -1, so compare signed.
  assign search_done = $signed({1'b0, l_q}) > r_q;
  assign mid_sum     = {1'b0, l_q} + r_q;
  assign mid         = (W+1)'(mid_sum >> 1);

  assign entry_addr = mem_data[address_size+data_size-1:data_size];
  assign entry_data = mem_data[data_size-1:0];

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, otherwise a path
    // that skips the assignment would infer a latch.
    state_d    = state_q;
    key_d      = key_q;
    l_d        = l_q;
    r_d        = r_q;
    probes_d   = probes_q;
    hit_d      = hit_q;
    data_d     = data_q;
    index_d    = index_q;
    rprobes_d  = rprobes_q;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    mem_index  = index_q[W-1:0];

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          key_d    = req_address;
          l_d      = '0;
          r_d      = $signed(r_init);
          probes_d = '0;
          state_d  = SEARCH;
        end
      end

      SEARCH: begin
        mem_index = mid[W-1:0];
        if (search_done) begin
          hit_d     = 1'b0;
          data_d    = '0;
          index_d   = l_q;
          rprobes_d = probes_q;
          state_d   = RESPOND;
        end else begin
          probes_d = probes_q + (W+1)'(1);
          if (entry_addr == key_q) begin
            hit_d     = 1'b1;
            data_d    = entry_data;
            index_d   = mid;
            rprobes_d = probes_q + (W+1)'(1);
            state_d   = RESPOND;
          end else if (entry_addr < key_q) begin
            l_d = mid + (W+1)'(1);
          end else begin
            r_d = $signed({1'b0, mid} - (W+2)'(1));
          end
        end
      end

      RESPOND: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_q     <= '0;
      l_q       <= '0;
      r_q       <= '0;
      probes_q  <= '0;
      hit_q     <= 1'b0;
      data_q    <= '0;
      index_q   <= '0;
      rprobes_q <= '0;
    end else begin
      key_q     <= key_d;
      l_q       <= l_d;
      r_q       <= r_d;
      probes_q  <= probes_d;
      hit_q     <= hit_d;
      data_q    <= data_d;
      index_q   <= index_d;
      rprobes_q <= rprobes_d;
    end
  end

  // Response fields are written only when leaving SEARCH, so they stay stable under backpressure.
  assign rsp_hit    = hit_q;
  assign rsp_data   = data_q;
  assign rsp_index  = index_q;
  assign rsp_probes = rprobes_q;

endmodule
